mux_nchan_scan: RTL

//   Registered N-channel, W-bit multiplexer; successor to the 4:1 single-bit mux.
//   Two modes: manual select, where S picks the channel, and auto scan, where the

---
 rtl/mux_nchan_scan.sv | 64 ++++++
 1 files changed

// File: rtl/mux_nchan_scan.sv
// mux_nchan_scan: registered N-channel W-bit mux with manual select and round-robin scan
module mux_nchan_scan #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int DWELL = 4,
  localparam int SEL_W = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] w,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          S,
  output logic [WIDTH-1:0]          f,
  output logic                      f_valid,
  output logic [SEL_W-1:0]          ch,
  output logic                      sel_err
);
  localparam int CNT_W = DWELL > 1 ? $clog2(DWELL) : 1;
  typedef enum logic [1:0] {IDLE, MAN, SCAN} state_t;
  state_t state, nxt;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;
  logic last;
  always_comb begin
    nxt = !en ? IDLE : mode ? SCAN : MAN;
    last = cnt == CNT_W'(DWELL - 1);
  end
  // valid follows the state that produced f: any scan cycle, or a manual cycle without a select error
  assign f_valid = state == SCAN || (state == MAN && !sel_err);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      f <= '0;
      ch <= '0;
      sel_err <= 1'b0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      state <= nxt;
      case (nxt)
        IDLE: sel_err <= 1'b0;
        MAN: begin
          ptr <= '0;
          cnt <= '0;
          ch <= S;
          if (32'(S) < CHANNELS) begin
            f <= w[S*WIDTH +: WIDTH];
            sel_err <= 1'b0;
          end else begin
            f <= '0;
            sel_err <= 1'b1;
          end
        end
        default: begin
          f <= w[ptr*WIDTH +: WIDTH];
          ch <= ptr;
          sel_err <= 1'b0;
          cnt <= last ? '0 : cnt + 1'b1;
          if (last) ptr <= ptr == SEL_W'(CHANNELS - 1) ? '0 : ptr + 1'b1;
        end
      endcase
    end
endmodule
